// File: rtl/mod_voice_scheduler_pkg.sv
// pkg_voice_sched: shared state encoding, voice config type and accumulator saturation.
package pkg_voice_sched;
  localparam int SAMPLE_RATE = 48000;
  localparam int Q_W = 32;
  localparam int SAT_W = 48;
  localparam logic signed [SAT_W-1:0] SAT_HI = 48'sh0000_7fff_ffff;
  localparam logic signed [SAT_W-1:0] SAT_LO = -48'sh0000_8000_0000;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} sched_state_e;
  typedef struct packed {
    logic [31:0] freq;
    logic        en;
  } voice_cfg_t;
  function automatic logic [Q_W-1:0] sat32(input logic signed [SAT_W-1:0] acc);
    return acc > SAT_HI ? 32'h7fff_ffff : acc < SAT_LO ? 32'h8000_0000 : acc[Q_W-1:0];
  endfunction
endpackage

// File: rtl/mod_voice_scheduler_bank.sv
// mod_voice_bank: pending/active double-buffered per-voice frequency and enable registers.
module mod_voice_bank
  import pkg_voice_sched::*;
#(
  parameter int NUM_VOICES = 8,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [VW-1:0] wr_idx,
  input  voice_cfg_t    wr_cfg,
  input  logic          snap,
  input  logic [VW-1:0] rd_idx,
  output voice_cfg_t    rd_cfg
);
  voice_cfg_t pending [NUM_VOICES];
  voice_cfg_t active [NUM_VOICES];
  // the snapshot takes the pre-write pending value, so a same-cycle write waits a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        pending[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (snap) active <= pending;
      if (we) pending[wr_idx] <= wr_cfg;
    end
  end
  assign rd_cfg = active[rd_idx];
endmodule

// File: rtl/mod_voice_scheduler.sv
// mod_voice_scheduler: shares one sine source across all voices each sample tick and mixes the results.
module mod_voice_scheduler
  import pkg_voice_sched::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_sample_tick,
  input  logic          i_cfg_we,
  input  logic [VW-1:0] i_cfg_voice,
  input  logic [31:0]   i_cfg_freq,
  input  logic          i_cfg_enable,
  output logic [31:0]   o_src_frequency,
  output logic [63:0]   o_src_time,
  output logic          o_src_trigger,
  input  logic          i_src_ready,
  input  logic [31:0]   i_src_sine,
  output logic [31:0]   o_mix,
  output logic          o_mix_valid,
  output logic          o_busy,
  output logic          o_overrun,
  output logic          o_timeout
);
  localparam int ACC_W = Q_W + VW;
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  sched_state_e state;
  logic [VW-1:0] idx;
  logic [WDW-1:0] wdog;
  logic signed [ACC_W-1:0] acc;
  logic [63:0] counter;
  voice_cfg_t wr_cfg, act;
  logic snap, last;
  assign wr_cfg = '{freq: i_cfg_freq, en: i_cfg_enable};
  assign snap = state == IDLE && i_sample_tick;
  assign last = idx == VW'(NUM_VOICES - 1);
  assign o_busy = state != IDLE;
  assign o_src_trigger = state == ISSUE && act.en;
  assign o_src_frequency = act.freq;
  mod_voice_bank #(.NUM_VOICES(NUM_VOICES)) u_bank (
    .clk(i_clk),
    .rst_n(i_nrst),
    .we(i_cfg_we),
    .wr_idx(i_cfg_voice),
    .wr_cfg(wr_cfg),
    .snap(snap),
    .rd_idx(idx),
    .rd_cfg(act)
  );
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
      idx <= '0;
      wdog <= '0;
      acc <= '0;
      counter <= '0;
      o_src_time <= '0;
      o_mix <= '0;
      o_mix_valid <= 1'b0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_mix_valid <= 1'b0;
      o_timeout <= 1'b0;
      o_overrun <= i_sample_tick && state != IDLE;
      if (i_sample_tick) counter <= counter + 64'd1;
      case (state)
        IDLE: if (i_sample_tick) begin
          o_src_time <= counter;
          idx <= '0;
          acc <= '0;
          state <= ISSUE;
        end
        ISSUE: if (act.en) begin
          wdog <= '0;
          state <= WAIT;
        end else if (last) state <= DONE;
        else idx <= idx + 1'b1;
        // a voice whose source never answers is dropped and contributes nothing
        WAIT: if (i_src_ready) state <= CAPTURE;
        else if (wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
          o_timeout <= 1'b1;
          state <= last ? DONE : ISSUE;
          idx <= last ? idx : idx + 1'b1;
        end else wdog <= wdog + 1'b1;
        CAPTURE: begin
          acc <= acc + {{VW{i_src_sine[31]}}, i_src_sine};
          state <= last ? DONE : ISSUE;
          idx <= last ? idx : idx + 1'b1;
        end
        DONE: begin
          o_mix <= sat32({{(SAT_W - ACC_W){acc[ACC_W-1]}}, acc});
          o_mix_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_voice_scheduler.sv
// tb_mod_voice_scheduler: directed frames against a stub sine source with a mix/source scoreboard.
`timescale 1ns/1ps
module tb_mod_voice_scheduler;
  localparam int N = 8;
  localparam int TO = 64;
  typedef struct {
    logic [31:0] freq;
    logic [63:0] t;
    bit          never;
    int          delay;
    logic [31:0] val;
  } src_exp_t;
  logic i_clk = 1'b0;
  logic i_nrst, i_sample_tick, i_cfg_we, i_cfg_enable, i_src_ready;
  logic [2:0] i_cfg_voice;
  logic [31:0] i_cfg_freq, i_src_sine;
  logic [31:0] o_src_frequency, o_mix;
  logic [63:0] o_src_time;
  logic o_src_trigger, o_mix_valid, o_busy, o_overrun, o_timeout;
  int n_assert = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int trig_cnt = 0;
  int tmo_cnt = 0;
  logic [31:0] exp_mix [$];
  src_exp_t exp_src [$];

  always #5 i_clk = ~i_clk;

  mod_voice_scheduler dut (
    .i_clk(i_clk),
    .i_nrst(i_nrst),
    .i_sample_tick(i_sample_tick),
    .i_cfg_we(i_cfg_we),
    .i_cfg_voice(i_cfg_voice),
    .i_cfg_freq(i_cfg_freq),
    .i_cfg_enable(i_cfg_enable),
    .o_src_frequency(o_src_frequency),
    .o_src_time(o_src_time),
    .o_src_trigger(o_src_trigger),
    .i_src_ready(i_src_ready),
    .i_src_sine(i_src_sine),
    .o_mix(o_mix),
    .o_mix_valid(o_mix_valid),
    .o_busy(o_busy),
    .o_overrun(o_overrun),
    .o_timeout(o_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cfg(input int v, input logic [31:0] f, input logic e);
    i_cfg_we = 1'b1;
    i_cfg_voice = 3'(v);
    i_cfg_freq = f;
    i_cfg_enable = e;
    step();
    i_cfg_we = 1'b0;
  endtask

  task automatic tick();
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
    tick_cnt++;
  endtask

  task automatic exp_voice(input logic [31:0] f, input bit nv, input int d, input logic [31:0] v);
    src_exp_t e;
    e.freq = f;
    e.t = 64'(tick_cnt);
    e.never = nv;
    e.delay = d;
    e.val = v;
    exp_src.push_back(e);
  endtask

  task automatic wait_frame(input string tag);
    int k = 0;
    while (exp_mix.size() != 0 && k < 400) begin
      step();
      k++;
    end
    check(tag, 64'(exp_mix.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " trigger"}, o_src_trigger, 0);
    check({tag, " busy"}, o_busy, 0);
    check({tag, " freq"}, o_src_frequency, 0);
    check({tag, " time"}, o_src_time, 0);
    check({tag, " mix"}, o_mix, 0);
    check({tag, " valid"}, o_mix_valid, 0);
    check({tag, " overrun"}, o_overrun, 0);
    check({tag, " timeout"}, o_timeout, 0);
  endtask

  // stub sine source: answers each trigger from the expectation queue
  initial begin
    src_exp_t e;
    int k;
    i_src_ready = 1'b0;
    i_src_sine = '0;
    forever begin
      step();
      while (o_src_trigger) begin
        trig_cnt++;
        if (exp_src.size() == 0) begin
          check("spurious trigger", 1, 0);
          step();
        end else begin
          e = exp_src.pop_front();
          check("src freq", o_src_frequency, e.freq);
          check("src time", o_src_time, e.t);
          if (e.never) begin
            k = 0;
            do begin
              step();
              k++;
            end while (!o_timeout && k < 200);
            check("timeout wait edges", k, TO + 1);
          end else begin
            repeat (1 + e.delay) step();
            i_src_ready = 1'b1;
            step();
            i_src_ready = 1'b0;
            i_src_sine = e.val;
            step();
            i_src_sine = '0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] m;
    forever begin
      step();
      if (o_timeout) tmo_cnt++;
      if (o_mix_valid) begin
        if (exp_mix.size() == 0) check("spurious mix_valid", 1, 0);
        else begin
          m = exp_mix.pop_front();
          check("mix", o_mix, m);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [63:0] ft;
    int tc, tt;
    i_nrst = 1'b0;
    i_sample_tick = 1'b0;
    i_cfg_we = 1'b0;
    i_cfg_voice = '0;
    i_cfg_freq = '0;
    i_cfg_enable = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    i_nrst = 1'b1;
    step();

    // no voices configured: valid exactly N+1 cycles after the tick edge
    tc = trig_cnt;
    exp_mix.push_back(32'h0);
    tick();
    check("busy after tick", o_busy, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("empty frame valid timing", o_mix_valid, 64'(k == N + 1));
    end
    check("empty frame idle", o_busy, 0);
    check("empty frame time", o_src_time, 0);
    check("empty frame triggers", 64'(trig_cnt - tc), 0);
    wait_frame("empty frame done");

    // voices 0 and 3
    cfg(0, 32'd440, 1'b1);
    cfg(3, 32'd1000, 1'b1);
    exp_voice(32'd440, 0, 0, 32'h0000_4000);
    exp_voice(32'd1000, 0, 0, 32'h0000_2000);
    exp_mix.push_back(32'h0000_6000);
    tc = trig_cnt;
    tick();
    wait_frame("two voice frame");
    check("two voice triggers", 64'(trig_cnt - tc), 2);

    // positive and negative saturation
    for (int i = 0; i < N; i++) cfg(i, 32'(100 + i), 1'b1);
    for (int i = 0; i < N; i++) exp_voice(32'(100 + i), 0, 0, 32'h7fff_0000);
    exp_mix.push_back(32'h7fff_ffff);
    tick();
    wait_frame("positive saturation frame");
    for (int i = 0; i < N; i++) exp_voice(32'(100 + i), 0, 0, 32'h8001_0000);
    exp_mix.push_back(32'h8000_0000);
    tick();
    wait_frame("negative saturation frame");

    // voice 2 never answers
    for (int i = 0; i < N; i++) cfg(i, 32'(200 + i), 1'b1);
    for (int i = 0; i < N; i++) exp_voice(32'(200 + i), i == 2, 0, 32'(16 * (i + 1)));
    exp_mix.push_back(32'h0000_0210);
    tt = tmo_cnt;
    tick();
    wait_frame("timeout frame");
    check("timeout pulses", 64'(tmo_cnt - tt), 1);

    // tick and config write during WAIT
    cfg(0, 32'd500, 1'b1);
    for (int i = 1; i < N; i++) cfg(i, 32'd0, 1'b0);
    exp_voice(32'd500, 0, 10, 32'h0000_1234);
    exp_mix.push_back(32'h0000_1234);
    tick();
    repeat (3) step();
    check("busy in wait", o_busy, 1);
    tick();
    check("overrun pulse", o_overrun, 1);
    cfg(0, 32'd777, 1'b1);
    check("overrun single cycle", o_overrun, 0);
    wait_frame("overrun frame");
    ft = o_src_time;
    exp_voice(32'd777, 0, 0, 32'h0000_0010);
    exp_mix.push_back(32'h0000_0010);
    tick();
    wait_frame("post overrun frame");
    check("time advance over overrun", o_src_time, ft + 64'd2);

    // asynchronous reset while waiting on the source
    cfg(0, 32'd900, 1'b1);
    exp_voice(32'd900, 0, 20, 32'h0000_0005);
    tick();
    repeat (4) step();
    check("busy before reset", o_busy, 1);
    #2;
    i_nrst = 1'b0;
    #1;
    check_reset_outputs("async reset");
    tick_cnt = 0;
    repeat (30) step();
    i_nrst = 1'b1;
    step();
    exp_mix.push_back(32'h0);
    tc = trig_cnt;
    tick();
    wait_frame("post reset frame");
    check("post reset time", o_src_time, 0);
    check("post reset triggers", 64'(trig_cnt - tc), 0);

    repeat (20) step();
    check("mix queue drained", 64'(exp_mix.size()), 0);
    check("source queue drained", 64'(exp_src.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
